// File: rtl/stage5_pkg.sv
// Shared definitions for the MIPS write-back stage and the control unit driving its select.
package stage5_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  // Write-back select encodings, shared with the control unit
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/stage5_writeback_if.sv
// MEM/WB boundary inputs and register-file write outputs of the write-back stage.
interface stage5_writeback_if;
  import stage5_pkg::*;

  logic              Reg_Write_En_in;
  logic [ADDR_W-1:0] Addr_Write_Reg_in;
  logic [DATA_W-1:0] ALU_Data;
  logic [DATA_W-1:0] Memory_Data;
  logic              WB_MUX_sel;

  logic              Reg_Write_En_out;
  logic [ADDR_W-1:0] Addr_Write_Reg_out;
  logic [DATA_W-1:0] Reg_Write_Data_out;

  // master drives the pipeline inputs; slave is the write-back stage itself
  modport master (
    output Reg_Write_En_in, Addr_Write_Reg_in, ALU_Data, Memory_Data, WB_MUX_sel,
    input  Reg_Write_En_out, Addr_Write_Reg_out, Reg_Write_Data_out
  );

  modport slave (
    input  Reg_Write_En_in, Addr_Write_Reg_in, ALU_Data, Memory_Data, WB_MUX_sel,
    output Reg_Write_En_out, Addr_Write_Reg_out, Reg_Write_Data_out
  );

endinterface

// File: rtl/stage5_writeback_wb_mux2.sv
// Parameterised 2:1 write-back data mux: ALU result or memory load data.
module wb_mux2
  import stage5_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_alu,
  input  logic [W-1:0] i_mem,
  output logic [W-1:0] o_y
);

  assign o_y = (i_sel == WB_SEL_MEM) ? i_mem : i_alu;

endmodule

// File: rtl/stage5_writeback.sv
// Write-back stage: selects register-file write data and forwards enable/address.
// Define STAGE5_WB_REG_OUT_EN to register all outputs (1-cycle latency).
module stage5_writeback
  import stage5_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  stage5_writeback_if.slave  wb
);

  logic [DATA_W-1:0] w_mux_data;
  wb_req_t           w_next;
  wb_req_t           w_out;

  wb_mux2 #(.W(DATA_W)) u_wb_mux2 (
    .i_sel (wb.WB_MUX_sel),
    .i_alu (wb.ALU_Data),
    .i_mem (wb.Memory_Data),
    .o_y   (w_mux_data)
  );

  // Address 0 passes through untouched; the register file discards $zero writes
  always_comb begin
    w_next      = '0;
    w_next.en   = wb.Reg_Write_En_in;
    w_next.addr = wb.Addr_Write_Reg_in;
    w_next.data = w_mux_data;
  end

`ifdef STAGE5_WB_REG_OUT_EN
  wb_req_t r_out;

  // Reset discards any pending write so the register file never sees a spurious enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_out <= '0;
    else       r_out <= w_next;
  end

  assign w_out = r_out;
`else
  logic w_unused_clk;
  assign w_unused_clk = clk;

  // Reset gate: outputs forced to zero while reset is high
  always_comb begin
    w_out = w_next;
    if (reset) w_out = '0;
  end
`endif

  assign wb.Reg_Write_En_out   = w_out.en;
  assign wb.Addr_Write_Reg_out = w_out.addr;
  assign wb.Reg_Write_Data_out = w_out.data;

endmodule

// File: tb/tb_stage5_writeback.sv
// Scoreboard bench for stage5_writeback; follows STAGE5_WB_REG_OUT_EN for latency.
module tb_stage5_writeback;
  import stage5_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  wb_req_t sb[$];
  wb_req_t prev_exp;

  stage5_writeback_if u_if ();

  stage5_writeback dut (
    .clk   (clk),
    .reset (reset),
    .wb    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_req(input string tag, input wb_req_t exp);
    check({tag, "_en"},   32'(u_if.Reg_Write_En_out),   32'(exp.en));
    check({tag, "_addr"}, 32'(u_if.Addr_Write_Reg_out), 32'(exp.addr));
    check({tag, "_data"}, 32'(u_if.Reg_Write_Data_out), 32'(exp.data));
  endtask

  task automatic pop_check(input string tag);
    wb_req_t e;
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_req(tag, e);
      prev_exp = e;
    end
  endtask

  function automatic wb_req_t model(input logic en, input logic [ADDR_W-1:0] addr,
                                    input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                                    input logic sel);
    wb_req_t r;
    r.en   = en;
    r.addr = addr;
    r.data = (sel === 1'b1) ? mem : alu;
    return r;
  endfunction

  task automatic apply(input string tag, input logic en, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                       input logic sel);
    @(negedge clk);
    u_if.Reg_Write_En_in   = en;
    u_if.Addr_Write_Reg_in = addr;
    u_if.ALU_Data          = alu;
    u_if.Memory_Data       = mem;
    u_if.WB_MUX_sel        = sel;
    sb.push_back(model(en, addr, alu, mem, sel));
`ifdef STAGE5_WB_REG_OUT_EN
    #1;
    check_req({tag, "_hold"}, prev_exp);
    @(posedge clk);
    #1;
`else
    #1;
`endif
    pop_check(tag);
  endtask

  // Reset asserted between edges, then released with the current inputs still applied
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('0);
    #1;
    pop_check({tag, "_asserted"});
    #2;
    reset = 1'b0;
    sb.push_back(model(u_if.Reg_Write_En_in, u_if.Addr_Write_Reg_in, u_if.ALU_Data,
                       u_if.Memory_Data, u_if.WB_MUX_sel));
`ifdef STAGE5_WB_REG_OUT_EN
    #1;
    check_req({tag, "_rel_hold"}, '0);
    @(posedge clk);
    #1;
`else
    #1;
`endif
    pop_check({tag, "_released"});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    prev_exp = '0;
    reset    = 1'b1;
    u_if.Reg_Write_En_in   = 1'b0;
    u_if.Addr_Write_Reg_in = '0;
    u_if.ALU_Data          = '0;
    u_if.Memory_Data       = '0;
    u_if.WB_MUX_sel        = WB_SEL_ALU;

    // Nonzero inputs during reset must not leak through
    repeat (2) @(negedge clk);
    u_if.Reg_Write_En_in   = 1'b1;
    u_if.Addr_Write_Reg_in = 5'd7;
    u_if.ALU_Data          = 32'h1234_5678;
    @(posedge clk);
    #1;
    check_req("in_reset", '0);
    @(negedge clk);
    u_if.Reg_Write_En_in   = 1'b0;
    u_if.Addr_Write_Reg_in = '0;
    u_if.ALU_Data          = '0;
    reset = 1'b0;

    apply("zeros",    1'b0, 5'd0,  32'd0, 32'd0, WB_SEL_ALU);
    apply("alu_sel",  1'b1, 5'd1,  32'd5, 32'd8, WB_SEL_ALU);
    apply("mem_sel",  1'b1, 5'd1,  32'd5, 32'd8, WB_SEL_MEM);
    reset_pulse("rst_mid");
    apply("full_alu", 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h8000_0001, WB_SEL_ALU);
    apply("full_mem", 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h8000_0001, WB_SEL_MEM);
    apply("addr0",    1'b1, 5'd0,  32'hAAAA_AAAA, 32'h5555_5555, WB_SEL_MEM);
    apply("en_off",   1'b0, 5'd19, 32'hDEAD_BEEF, 32'hCAFE_F00D, WB_SEL_ALU);

    for (int i = 0; i < 8; i++) begin
      apply($sformatf("rand%0d", i), 1'($urandom_range(1)), 5'($urandom_range(31)),
            32'($urandom), 32'($urandom), 1'($urandom_range(1)));
    end

    reset_pulse("rst_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
